// File: rtl/rx_udp.sv
// UDP receive stage: parses the 8-byte header, filters on destination port and forwards length-8 payload bytes.
// Latency: 1 cycle registered for payload bytes; irq/err pulse 1 cycle after the end-of-frame rising edge is sampled.
// Backpressure: none, every valid byte is consumed; func_en low freezes all state and silences pulse outputs.
module rx_udp #(
  parameter int OCT = 8
) (
  input  logic           RX_CLK,
  input  logic           rst_n,
  input  logic           func_en,
  input  logic [15:0]    udp_port,
  input  logic           rx_ipv4_irq,
  input  logic           rx_ipv4_data_v,
  input  logic [OCT-1:0] rx_ipv4_data,
  output logic [15:0]    rx_src_port,
  output logic [15:0]    rx_dst_port,
  output logic [15:0]    rx_udp_len,
  output logic           rx_udp_data_v,
  output logic [OCT-1:0] rx_udp_data,
  output logic           rx_udp_irq,
  output logic           rx_udp_err
);

  localparam logic [1:0] HDR     = 2'd0;
  localparam logic [1:0] PAYLOAD = 2'd1;
  localparam logic [1:0] DROP    = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]  state;
  logic [2:0]  hdr_cnt;
  logic [15:0] rem;
  logic        bad;
  logic        irq_q;
  logic        data_v_q;
  logic        irq_p;
  logic        err_p;
  logic        frame_end;

  // End of frame is the rising edge of the upstream irq level.
  assign frame_end = rx_ipv4_irq & ~irq_q;

  // Pulse outputs are silenced immediately while the block is disabled.
  assign rx_udp_data_v = data_v_q & func_en;
  assign rx_udp_irq    = irq_p & func_en;
  assign rx_udp_err    = err_p & func_en;

  // Header parse, payload forwarding and frame-end bookkeeping.
  always_ff @(posedge RX_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HDR;
      hdr_cnt     <= 3'd0;
      rem         <= 16'd0;
      bad         <= 1'b0;
      irq_q       <= 1'b0;
      data_v_q    <= 1'b0;
      irq_p       <= 1'b0;
      err_p       <= 1'b0;
      rx_udp_data <= '0;
      rx_src_port <= 16'd0;
      rx_dst_port <= 16'd0;
      rx_udp_len  <= 16'd0;
    end else begin
      data_v_q <= 1'b0;
      irq_p    <= 1'b0;
      err_p    <= 1'b0;
      if (func_en) begin
        irq_q <= rx_ipv4_irq;
        if (frame_end) begin
          // DONE is only reachable with a matching port, so it alone means success.
          irq_p   <= (state == DONE);
          err_p   <= ((state == HDR) && (hdr_cnt != 3'd0)) || (state == PAYLOAD) || bad;
          state   <= HDR;
          hdr_cnt <= 3'd0;
          rem     <= 16'd0;
          bad     <= 1'b0;
        end else if (rx_ipv4_data_v) begin
          case (state)
            HDR: begin
              hdr_cnt <= hdr_cnt + 3'd1;
              case (hdr_cnt)
                3'd0, 3'd1: rx_src_port <= {rx_src_port[15-OCT:0], rx_ipv4_data};
                3'd2, 3'd3: rx_dst_port <= {rx_dst_port[15-OCT:0], rx_ipv4_data};
                3'd4, 3'd5: rx_udp_len  <= {rx_udp_len[15-OCT:0], rx_ipv4_data};
                3'd7: begin
                  // Checksum is ignored; length and port are already complete here.
                  if (rx_udp_len < 16'd8) begin
                    state <= DROP;
                    bad   <= 1'b1;
                  end else if (rx_dst_port != udp_port) begin
                    state <= DROP;
                  end else if (rx_udp_len == 16'd8) begin
                    state <= DONE;
                  end else begin
                    state <= PAYLOAD;
                    rem   <= rx_udp_len - 16'd8;
                  end
                end
                default: ;
              endcase
            end
            PAYLOAD: begin
              data_v_q    <= 1'b1;
              rx_udp_data <= rx_ipv4_data;
              rem         <= rem - 16'd1;
              if (rem == 16'd1) state <= DONE;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_rx_udp.sv
// Directed bench for rx_udp: table of whole frames plus hand-written corner sequences.
// Inputs change 1 time unit after the rising edge; outputs are observed on the falling edge.
// A falling-edge monitor collects forwarded bytes and counts irq/err pulses.
module tb_rx_udp;

  logic        RX_CLK = 1'b0;
  logic        rst_n = 1'b0;
  logic        func_en = 1'b1;
  logic [15:0] udp_port = 16'h0400;
  logic        rx_ipv4_irq = 1'b0;
  logic        rx_ipv4_data_v = 1'b0;
  logic [7:0]  rx_ipv4_data = 8'h00;
  logic [15:0] rx_src_port, rx_dst_port, rx_udp_len;
  logic        rx_udp_data_v;
  logic [7:0]  rx_udp_data;
  logic        rx_udp_irq, rx_udp_err;

  rx_udp #(.OCT(8)) dut (
    .RX_CLK(RX_CLK), .rst_n(rst_n), .func_en(func_en), .udp_port(udp_port),
    .rx_ipv4_irq(rx_ipv4_irq), .rx_ipv4_data_v(rx_ipv4_data_v), .rx_ipv4_data(rx_ipv4_data),
    .rx_src_port(rx_src_port), .rx_dst_port(rx_dst_port), .rx_udp_len(rx_udp_len),
    .rx_udp_data_v(rx_udp_data_v), .rx_udp_data(rx_udp_data),
    .rx_udp_irq(rx_udp_irq), .rx_udp_err(rx_udp_err)
  );

  always #5 RX_CLK = ~RX_CLK;

  int n_pass = 0;
  int n_total = 0;
  logic [7:0] fwd_q[$];
  logic [7:0] sent_q[$];
  int irq_cnt = 0;
  int err_cnt = 0;

  // Observe outputs on the falling edge, away from the active edge.
  always @(negedge RX_CLK) begin
    if (rx_udp_data_v) fwd_q.push_back(rx_udp_data);
    if (rx_udp_irq) irq_cnt++;
    if (rx_udp_err) err_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge RX_CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_ipv4_data_v = 1'b1;
    rx_ipv4_data   = b;
    tick();
    rx_ipv4_data_v = 1'b0;
  endtask

  task automatic send_hdr(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len);
    send_byte(src[15:8]); send_byte(src[7:0]);
    send_byte(dst[15:8]); send_byte(dst[7:0]);
    send_byte(len[15:8]); send_byte(len[7:0]);
    send_byte(8'hAB);     send_byte(8'hCD);
  endtask

  task automatic frame_end();
    rx_ipv4_irq = 1'b1;
    tick(); tick(); tick();
    rx_ipv4_irq = 1'b0;
    tick(); tick();
  endtask

  task automatic clear_obs();
    fwd_q.delete();
    sent_q.delete();
    irq_cnt = 0;
    err_cnt = 0;
  endtask

  task automatic chk_bytes(input string name, input int exp_n);
    int ok;
    chk({name, "_count"}, fwd_q.size(), exp_n);
    ok = (fwd_q.size() == exp_n) ? 1 : 0;
    for (int i = 0; i < exp_n && ok == 1; i++)
      if (i >= sent_q.size() || fwd_q[i] !== sent_q[i]) ok = 0;
    chk({name, "_content"}, ok, 1);
  endtask

  typedef struct {
    string       name;
    logic [15:0] port;
    logic [15:0] src;
    logic [15:0] dst;
    logic [15:0] len;
    int          nbytes;   // bytes after the header, payload plus trailer
    logic [79:0] pay;
    int          exp_n;
    int          exp_irq;
    int          exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic run_frame(input vec_t v);
    logic [7:0] b;
    clear_obs();
    udp_port = v.port;
    send_hdr(v.src, v.dst, v.len);
    for (int i = 0; i < v.nbytes; i++) begin
      b = v.pay[79-8*i -: 8];
      sent_q.push_back(b);
      send_byte(b);
    end
    frame_end();
  endtask

  initial begin
    vecs[0] = '{"good",     16'h0400, 16'h1234, 16'h0400, 16'h000C, 10, 80'hDEADBEEF_000000000000, 4, 1, 0};
    vecs[1] = '{"mismatch", 16'h0401, 16'h1234, 16'h0400, 16'h000C, 10, 80'hDEADBEEF_000000000000, 0, 0, 0};
    vecs[2] = '{"badlen",   16'h0400, 16'h1111, 16'h0400, 16'h0005, 4,  80'h01020304_000000000000, 0, 0, 1};
    vecs[3] = '{"badlen_mm",16'h0400, 16'h1112, 16'h0999, 16'h0007, 2,  80'h0102_0000000000000000, 0, 0, 1};
    vecs[4] = '{"trunc",    16'h0400, 16'h2222, 16'h0400, 16'h0010, 3,  80'h112233_00000000000000, 3, 0, 1};
    vecs[5] = '{"empty",    16'h0400, 16'h3333, 16'h0400, 16'h0008, 2,  80'h5566_0000000000000000, 0, 1, 0};
    vecs[6] = '{"good_b2b", 16'h0400, 16'h1234, 16'h0400, 16'h000C, 10, 80'hDEADBEEF_A1A2A3A4A5A6, 4, 1, 0};
    vecs[7] = '{"len9",     16'hBEEF, 16'h4444, 16'hBEEF, 16'h0009, 4,  80'h77889900_000000000000, 1, 1, 0};

    // Reset state while rst_n is held low.
    #12;
    chk("rst_src", rx_src_port, 16'h0);
    chk("rst_dst", rx_dst_port, 16'h0);
    chk("rst_len", rx_udp_len, 16'h0);
    chk("rst_pulses", {rx_udp_data_v, rx_udp_irq, rx_udp_err}, 3'b000);
    chk("rst_data", rx_udp_data, 8'h00);
    tick();
    rst_n = 1'b1;
    tick(); tick();

    for (int k = 0; k < 8; k++) begin
      run_frame(vecs[k]);
      chk_bytes(vecs[k].name, vecs[k].exp_n);
      chk({vecs[k].name, "_irq"}, irq_cnt, vecs[k].exp_irq);
      chk({vecs[k].name, "_err"}, err_cnt, vecs[k].exp_err);
      chk({vecs[k].name, "_src"}, rx_src_port, vecs[k].src);
      chk({vecs[k].name, "_dst"}, rx_dst_port, vecs[k].dst);
      chk({vecs[k].name, "_len"}, rx_udp_len, vecs[k].len);
    end

    // Frame end coincides with a valid byte: the byte is dropped, frame is truncated.
    clear_obs();
    udp_port = 16'h0400;
    send_hdr(16'h5555, 16'h0400, 16'h000A);
    sent_q.push_back(8'h3C);
    send_byte(8'h3C);
    rx_ipv4_data_v = 1'b1;
    rx_ipv4_data   = 8'h3D;
    rx_ipv4_irq    = 1'b1;
    tick();
    rx_ipv4_data_v = 1'b0;
    tick(); tick();
    rx_ipv4_irq = 1'b0;
    tick(); tick();
    chk_bytes("same_cycle", 1);
    chk("same_cycle_irq", irq_cnt, 0);
    chk("same_cycle_err", err_cnt, 1);

    // func_en low for 3 cycles mid-header, with bytes offered meanwhile: they are ignored.
    clear_obs();
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h04);
    func_en = 1'b0;
    for (int i = 0; i < 3; i++) send_byte(8'hFF);
    func_en = 1'b1;
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h0C); send_byte(8'hAB); send_byte(8'hCD);
    for (int i = 0; i < 4; i++) begin
      sent_q.push_back(8'hC0 + 8'(i));
      send_byte(8'hC0 + 8'(i));
    end
    frame_end();
    chk_bytes("func_en", 4);
    chk("func_en_irq", irq_cnt, 1);
    chk("func_en_err", err_cnt, 0);
    chk("func_en_dst", rx_dst_port, 16'h0400);

    // Asynchronous reset mid-payload: outputs clear at once, no pulse, next frame parses cleanly.
    clear_obs();
    send_hdr(16'h6666, 16'h0400, 16'h000C);
    send_byte(8'h01);
    rx_ipv4_data_v = 1'b1;
    rx_ipv4_data   = 8'h02;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_regs", {rx_src_port, rx_dst_port}, 32'h0);
    chk("arst_outs", {rx_udp_len, rx_udp_data, rx_udp_data_v, rx_udp_irq, rx_udp_err}, 27'h0);
    rx_ipv4_data_v = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("arst_no_pulse", irq_cnt + err_cnt, 0);
    run_frame(vecs[0]);
    chk_bytes("after_rst", 4);
    chk("after_rst_irq", irq_cnt, 1);
    chk("after_rst_err", err_cnt, 0);
    chk("after_rst_src", rx_src_port, 16'h1234);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
